dm_arb: RTL and testbench
=========================

DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 Parameter DM_AW, default 7, SHALL set the word-address width driven to data memory (128 words).
REQ-002 Port clk, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: SHALL be the reset, synchronous and active-high.
REQ-004 Ports rN_req (N=0,1), input, 1: SHALL be the access request, held until rN_gnt.
REQ-005 Ports rN_we, input, 1: SHALL select store (1) or load (0).
REQ-006 Ports rN_addr, input, 9: SHALL be the byte address.
REQ-007 Ports rN_size, input, 2: SHALL encode access size: 00 byte, 01 half, 10/11 word.
REQ-008 Ports rN_sext, input, 1: SHALL select sign-extension (1) or zero-extension (0) for sub-word loads.
REQ-009 Ports rN_wdata, input, 32: SHALL be store data, right-aligned.
REQ-010 Ports rN_gnt, output, 1: SHALL be a one-cycle acceptance pulse.
REQ-011 Ports rN_rvalid, output, 1: SHALL be a one-cycle completion pulse.
REQ-012 Ports rN_rdata, output, 32: SHALL be load result; rN_err, output, 1: SHALL flag misalignment.
REQ-013 Ports dm_wr (out 1), dm_addr (out DM_AW), dm_din (out 32), dm_memop (out 2), dm_dout (in 32): SHALL connect to data memory, dm_dout combinational.

Function
REQ-014 FSM states IDLE, ACC, MERGE, RESP; grants SHALL be issued only in IDLE.
REQ-015 Arbitration SHALL be round-robin on last-granted pointer; on simultaneous requests the requester not last granted SHALL win; r0 SHALL win the first tie after reset.
REQ-016 On grant (cycle T) we/addr/size/sext/wdata SHALL be captured; FSM SHALL enter ACC at T+1.
REQ-017 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) SHALL skip memory: ACC->RESP, dm_wr=0, rdata=0, err=1.
REQ-018 Load: ACC SHALL extract lane from dm_dout (little-endian, byte lane addr[1:0], half lane addr[1]), extend per sext, register it; RESP at T+2.
REQ-019 Word store: ACC SHALL drive dm_wr=1, dm_din=wdata; RESP at T+2.
REQ-020 Sub-word store: ACC SHALL read and register dm_dout; MERGE SHALL write word with only the addressed lane replaced; RESP at T+3.
REQ-021 dm_addr SHALL equal captured addr[8:2] in ACC/MERGE; dm_memop SHALL be constant 2'b11 (full word); dm_wr SHALL pulse exactly once per aligned store and never otherwise.
REQ-022 RESP SHALL pulse rvalid (and err) only to the owning requester, then return to IDLE; throughput 1 op per 3 (4 for sub-word store) cycles.
REQ-023 rN_rdata SHALL hold its value until that requester's next rvalid; stores SHALL leave it unchanged.
REQ-024 Deasserting rN_req before grant SHALL withdraw the request with no side effect.

Reset
REQ-025 rst SHALL force IDLE, pointer to favour r0, all gnt/rvalid/err/dm_wr=0, rdata=0, dm_addr=0, dm_din=0.
REQ-026 rst in any state (including MERGE) SHALL suppress that cycle's dm_wr and discard the operation without rvalid.

Structure
REQ-027 Shared package dm_arb_pkg SHALL hold size encodings, FSM state encodings and DM_MEMOP_WORD.
REQ-028 One combinational sub-module dm_lane SHALL perform load extraction and store merge.

Verification
REQ-029 After reset, r0 word store 0xDEADBEEF @0x010 -> gnt T, dm_wr=1 T+1 with dm_addr=4, dm_din=0xDEADBEEF, rvalid T+2.
REQ-030 Word 0x11223344 @0x010; r1 byte store 0xAA @0x013 -> single dm_wr at T+2 with dm_din=0xAA223344, rvalid T+3.
REQ-031 Word 0xAA223344; byte load @0x013 sext=1 -> 0xFFFFFFAA, sext=0 -> 0x000000AA; half load @0x012 sext=1 -> 0xFFFFAA22.
REQ-032 r0 and r1 request continuously -> grants alternate r0,r1,r0,r1; no rvalid to the wrong requester.
REQ-033 Half load @0x011 -> err=1, rdata=0, no dm_wr, rvalid T+2.
REQ-034 rst asserted in MERGE of a byte store -> no dm_wr, no rvalid, memory unchanged; next request granted normally.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// dm_arb shared definitions: access sizes, FSM encodings
// and the captured-request bundle.
package dm_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ACC   = 2'b01;
    localparam logic [1:0] ST_MERGE = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    localparam logic [1:0] DM_MEMOP_WORD = 2'b11;

    typedef struct packed {
        logic        we;
        logic [8:0]  addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] wdata;
    } dm_op_t;

    // 2'b11 is treated as a word access
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] ofs
    );
        return (size == SZ_HALF && ofs[0]) ||
               (is_word(size) && ofs != 2'b00);
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte/half lane extraction for loads and lane merge
// for sub-word stores on a little-endian 32-bit word.
module dm_lane
    import dm_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ofs,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    assign sh   = {ofs, 3'b000};
    assign lane = word >> sh;

    always_comb begin
        ldata = word;
        mask  = 32'hFFFF_FFFF;
        if (size == SZ_BYTE) begin
            ldata = {{24{sext & lane[7]}}, lane[7:0]};
            mask  = 32'h0000_00FF << sh;
        end else if (!is_word(size)) begin
            ldata = {{16{sext & lane[15]}}, lane[15:0]};
            mask  = 32'h0000_FFFF << sh;
        end
        mdata = (word & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/dm_arb.sv
// Two-requester round-robin data-memory port with
// sub-word load extraction and read-merge-write stores.
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int DM_AW = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic             r0_we,
    input  logic [8:0]       r0_addr,
    input  logic [1:0]       r0_size,
    input  logic             r0_sext,
    input  logic [31:0]      r0_wdata,
    output logic             r0_gnt,
    output logic             r0_rvalid,
    output logic [31:0]      r0_rdata,
    output logic             r0_err,
    input  logic             r1_req,
    input  logic             r1_we,
    input  logic [8:0]       r1_addr,
    input  logic [1:0]       r1_size,
    input  logic             r1_sext,
    input  logic [31:0]      r1_wdata,
    output logic             r1_gnt,
    output logic             r1_rvalid,
    output logic [31:0]      r1_rdata,
    output logic             r1_err,
    output logic             dm_wr,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic [1:0]       dm_memop,
    input  logic [31:0]      dm_dout
);

    logic [1:0]  state;
    dm_op_t      op;
    dm_op_t      nxt;
    logic        own;
    logic        last;
    logic [31:0] saved;
    logic        any;
    logic        pick;
    logic        grant;
    logic        resp;
    logic        mis;
    logic        sub_st;
    logic [31:0] lword;
    logic [31:0] ldata;
    logic [31:0] mdata;

    // on a tie the requester not granted last time wins
    assign any   = r0_req | r1_req;
    assign pick  = (r0_req & r1_req) ? ~last : r1_req;
    assign grant = !rst && state == ST_IDLE && any;

    assign r0_gnt = grant & ~pick;
    assign r1_gnt = grant & pick;

    assign nxt = pick
        ? {r1_we, r1_addr, r1_size, r1_sext, r1_wdata}
        : {r0_we, r0_addr, r0_size, r0_sext, r0_wdata};

    assign mis    = misaligned(op.size, op.addr[1:0]);
    assign sub_st = op.we && !is_word(op.size);
    assign lword  = (state == ST_MERGE) ? saved : dm_dout;

    dm_lane u_lane (
        .word  (lword),
        .ofs   (op.addr[1:0]),
        .size  (op.size),
        .sext  (op.sext),
        .wdata (op.wdata),
        .ldata (ldata),
        .mdata (mdata)
    );

    assign resp      = !rst && state == ST_RESP;
    assign r0_rvalid = resp & ~own;
    assign r1_rvalid = resp & own;
    assign r0_err    = r0_rvalid & mis;
    assign r1_err    = r1_rvalid & mis;
    assign dm_memop  = DM_MEMOP_WORD;

    always_comb begin
        dm_wr   = 1'b0;
        dm_din  = '0;
        dm_addr = '0;
        if (!rst) begin
            unique case (1'b1)
                state == ST_ACC: begin
                    dm_addr = DM_AW'(op.addr[8:2]);
                    if (op.we && !mis && !sub_st) begin
                        dm_wr  = 1'b1;
                        dm_din = op.wdata;
                    end
                end
                state == ST_MERGE: begin
                    dm_addr = DM_AW'(op.addr[8:2]);
                    dm_wr   = 1'b1;
                    dm_din  = mdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op       <= '0;
            own      <= 1'b0;
            last     <= 1'b1;
            saved    <= '0;
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any) begin
                        op    <= nxt;
                        own   <= pick;
                        last  <= pick;
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (mis) begin
                        state <= ST_RESP;
                        if (own) r1_rdata <= '0;
                        else     r0_rdata <= '0;
                    end else if (sub_st) begin
                        saved <= dm_dout;
                        state <= ST_MERGE;
                    end else begin
                        state <= ST_RESP;
                        if (!op.we) begin
                            if (own) r1_rdata <= ldata;
                            else     r0_rdata <= ldata;
                        end
                    end
                end
                ST_MERGE: state <= ST_RESP;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// Self-checking bench for dm_arb: directed scenarios plus
// random traffic against a byte-array memory model.
module tb_dm_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 0, r0_we = 0, r0_sext = 0;
    logic [8:0]  r0_addr = 0;
    logic [1:0]  r0_size = 0;
    logic [31:0] r0_wdata = 0;
    logic        r1_req = 0, r1_we = 0, r1_sext = 0;
    logic [8:0]  r1_addr = 0;
    logic [1:0]  r1_size = 0;
    logic [31:0] r1_wdata = 0;
    logic        r0_gnt, r0_rvalid, r0_err;
    logic        r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        dm_wr;
    logic [6:0]  dm_addr;
    logic [31:0] dm_din;
    logic [1:0]  dm_memop;
    logic [31:0] dm_dout;

    always #5 clk = ~clk;

    dm_arb #(.DM_AW(7)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_size(r0_size), .r0_sext(r0_sext),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_size(r1_size), .r1_sext(r1_sext),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .r1_err(r1_err),
        .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_memop(dm_memop), .dm_dout(dm_dout)
    );

    // physical data memory seen by the DUT
    logic [31:0] mem [128] = '{default: 32'h0};
    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_din;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wr_cnt = 0;
    logic [6:0]  wr_addr = 0;
    logic [31:0] wr_din = 0;
    int          gnt_cnt [2] = '{0, 0};
    int          rv_cnt [2] = '{0, 0};
    always @(negedge clk) begin
        if (dm_wr) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= dm_addr;
            wr_din  <= dm_din;
        end
        if (r0_gnt) gnt_cnt[0] <= gnt_cnt[0] + 1;
        if (r1_gnt) gnt_cnt[1] <= gnt_cnt[1] + 1;
        if (r0_rvalid) rv_cnt[0] <= rv_cnt[0] + 1;
        if (r1_rvalid) rv_cnt[1] <= rv_cnt[1] + 1;
    end

    int checks = 0;
    int failures = 0;

    // reference: byte-addressed memory and per-requester result
    logic [7:0]  rm [512] = '{default: 8'h0};
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rword(input int a);
        int b;
        b = a & ~3;
        return {rm[b+3], rm[b+2], rm[b+1], rm[b]};
    endfunction

    function automatic logic [31:0] rload(input int a,
                                          input int n,
                                          input logic sx);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(rm[a+i]) << (8 * i);
        if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic set_req(input int p, input logic rq,
                           input logic we, input logic [8:0] a,
                           input logic [1:0] sz, input logic sx,
                           input logic [31:0] wd);
        if (p == 0) begin
            r0_req = rq; r0_we = we; r0_addr = a;
            r0_size = sz; r0_sext = sx; r0_wdata = wd;
        end else begin
            r1_req = rq; r1_we = we; r1_addr = a;
            r1_size = sz; r1_sext = sx; r1_wdata = wd;
        end
    endtask

    task automatic do_op(input int p, input logic we,
                         input logic [8:0] a,
                         input logic [1:0] sz,
                         input logic sx,
                         input logic [31:0] wd);
        int n, lat, ewr, gc, k, wc0, xr0;
        logic mis, seen;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 0);
        lat = 2;
        ewr = 0;
        if (mis) exp_rd[p] = 32'h0;
        else if (!we) exp_rd[p] = rload(int'(a), n, sx);
        else begin
            ewr = 1;
            if (n < 4) lat = 3;
            for (int i = 0; i < n; i++)
                rm[int'(a)+i] = 8'(wd >> (8 * i));
        end
        wc0 = wr_cnt;
        xr0 = rv_cnt[1-p];
        @(posedge clk); #1;
        set_req(p, 1'b1, we, a, sz, sx, wd);
        seen = 0; k = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            seen = (p == 0) ? r0_gnt : r1_gnt;
            k++;
        end
        chk("gnt_seen", 32'(seen), 32'd1);
        gc = cyc;
        @(posedge clk); #1;
        set_req(p, 1'b0, we, a, sz, sx, wd);
        seen = 0; k = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            seen = (p == 0) ? r0_rvalid : r1_rvalid;
            k++;
        end
        chk("rvalid_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc - gc), 32'(lat));
        chk("err", 32'((p == 0) ? r0_err : r1_err), 32'(mis));
        chk("rdata", (p == 0) ? r0_rdata : r1_rdata, exp_rd[p]);
        @(posedge clk); #1;
        chk("wr_count", 32'(wr_cnt - wc0), 32'(ewr));
        chk("wrong_rvalid", 32'(rv_cnt[1-p] - xr0), 32'd0);
        if (ewr != 0) begin
            chk("wr_addr", 32'(wr_addr), 32'(a >> 2));
            chk("wr_din", wr_din, rword(int'(a)));
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        r0_req = 1'b1;
        r1_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", 32'(r0_gnt), 32'd0);
        chk("rst_gnt1", 32'(r1_gnt), 32'd0);
        chk("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
        chk("rst_err", 32'({r0_err, r1_err}), 32'd0);
        chk("rst_dm_wr", 32'(dm_wr), 32'd0);
        chk("rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("rst_dm_din", dm_din, 32'd0);
        chk("rst_rdata0", r0_rdata, 32'd0);
        chk("rst_rdata1", r1_rdata, 32'd0);
        chk("memop", 32'(dm_memop), 32'd3);
        r0_req = 1'b0;
        r1_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
    endtask

    initial begin
        int seq[$];
        int owner, bad, k, g1, w0, v0, v1;
        logic [8:0] a;

        apply_reset();

        do_op(0, 1, 9'h010, 2'b10, 0, 32'hDEADBEEF);
        do_op(0, 1, 9'h010, 2'b10, 0, 32'h11223344);
        do_op(1, 1, 9'h013, 2'b00, 0, 32'h000000AA);
        chk("mem_word4", mem[4], 32'hAA223344);
        do_op(0, 0, 9'h013, 2'b00, 1, 32'h0);
        chk("byte_sext", r0_rdata, 32'hFFFFFFAA);
        do_op(1, 0, 9'h013, 2'b00, 0, 32'h0);
        chk("byte_zext", r1_rdata, 32'h000000AA);
        do_op(0, 0, 9'h012, 2'b01, 1, 32'h0);
        chk("half_sext", r0_rdata, 32'hFFFFAA22);
        do_op(1, 1, 9'h012, 2'b01, 0, 32'h00005566);
        do_op(1, 0, 9'h011, 2'b01, 1, 32'h0);
        do_op(0, 0, 9'h010, 2'b11, 0, 32'h0);

        apply_reset();

        // continuous requests from both sides
        set_req(0, 1'b1, 1'b0, 9'h010, 2'b10, 1'b0, 32'h0);
        set_req(1, 1'b1, 1'b0, 9'h010, 2'b10, 1'b0, 32'h0);
        owner = -1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r0_rvalid && owner != 0) bad++;
            if (r1_rvalid && owner != 1) bad++;
            if (r0_gnt) begin seq.push_back(0); owner = 0; end
            if (r1_gnt) begin seq.push_back(1); owner = 1; end
        end
        @(posedge clk); #1;
        r0_req = 1'b0;
        r1_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (r0_rvalid && owner != 0) bad++;
            if (r1_rvalid && owner != 1) bad++;
        end
        chk("rr_grants", 32'(seq.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            chk("rr_order", 32'((seq.size() > i) ? seq[i] : -1),
                32'(i % 2));
        chk("rr_rvalid_owner", 32'(bad), 32'd0);
        exp_rd[0] = rword(16);
        exp_rd[1] = rword(16);

        // request raised and withdrawn while busy
        g1 = gnt_cnt[1];
        fork
            do_op(0, 1, 9'h020, 2'b10, 0, 32'hCAFEF00D);
            begin
                k = 0;
                while (!r0_gnt && k < 30) begin
                    @(negedge clk);
                    k++;
                end
                @(posedge clk); #1;
                set_req(1, 1'b1, 1'b1, 9'h0F0, 2'b10, 1'b0,
                        32'h12345678);
                @(posedge clk); #1;
                r1_req = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("withdraw_gnt", 32'(gnt_cnt[1] - g1), 32'd0);
        do_op(1, 0, 9'h0F0, 2'b10, 0, 32'h0);

        // reset while the byte store is in its merge cycle
        w0 = wr_cnt;
        v0 = rv_cnt[0];
        v1 = rv_cnt[1];
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b1, 9'h021, 2'b00, 1'b0, 32'h55);
        k = 0;
        while (!r1_gnt && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("merge_gnt", 32'(r1_gnt), 32'd1);
        @(posedge clk); #1;
        r1_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("merge_rst_wr", 32'(dm_wr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        chk("merge_rst_wrcnt", 32'(wr_cnt - w0), 32'd0);
        chk("merge_rst_rv",
            32'((rv_cnt[0] - v0) + (rv_cnt[1] - v1)), 32'd0);
        chk("merge_rst_mem", mem[8], 32'hCAFEF00D);
        do_op(1, 0, 9'h021, 2'b00, 0, 32'h0);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            a = 9'h100 + 9'($urandom % 64);
            if ($urandom % 4 == 0) a = 9'($urandom % 512);
            do_op(int'($urandom % 2), 1'($urandom % 2), a,
                  2'($urandom % 4), 1'($urandom % 2), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
